// File: rtl/lzw_stream_enc.sv
// Streaming LZW encoder: valid/ready/last bytes in, fixed-width codes out, per-frame dictionary.
// Optional feature macro LZW_DICT_CLEAR_EN: emit a CLR code and restart the dictionary when it fills.
module lzw_stream_enc #(
    parameter int unsigned SYM_W      = 8,
    parameter int unsigned DICT_DEPTH = 64,
    parameter int unsigned CODE_W     = 12
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              s_valid_i,
    input  logic [SYM_W-1:0]  s_data_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic              m_valid_o,
    output logic [CODE_W-1:0] m_code_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic              dict_full_o,
    output logic              busy_o
);

    localparam int unsigned LIT_N = 2**SYM_W;
    localparam int unsigned IDX_W = (DICT_DEPTH > 1) ? $clog2(DICT_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DICT_DEPTH + 1);
    localparam logic [CODE_W-1:0] LIT_BASE = CODE_W'(LIT_N);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DICT_DEPTH);
`ifdef LZW_DICT_CLEAR_EN
    localparam logic [CODE_W-1:0] CLR_CODE = '1;
`endif

    generate
        if (2**CODE_W <= 2**SYM_W + DICT_DEPTH) begin : g_bad_cfg
            $error("lzw_stream_enc: CODE_W too narrow for SYM_W and DICT_DEPTH");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DONE  = 3'd3,
        ST_CLR   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CODE_W-1:0]   r_str;
    logic [CNT_W-1:0]    r_count;
    logic                r_m_valid;
    logic [CODE_W-1:0]   r_m_code;
    logic                r_m_last;
    logic                r_dict_full;
    logic                r_busy;
    logic [CODE_W-1:0]   r_ent_prefix [DICT_DEPTH];
    logic [SYM_W-1:0]    r_ent_sym    [DICT_DEPTH];
`ifdef LZW_DICT_CLEAR_EN
    logic                r_pend_last;
    logic                w_pend_last_nxt;
`endif

    logic                w_slot_free;
    logic                w_s_fire;
    logic                w_m_fire;
    logic                w_full;
    logic                w_hit;
    logic [IDX_W-1:0]    w_hit_idx;
    logic [CODE_W-1:0]   w_hit_code;
    logic [IDX_W-1:0]    w_wr_idx;
    logic                w_load;
    logic [CODE_W-1:0]   w_load_code;
    logic                w_load_last;
    logic [CODE_W-1:0]   w_str_nxt;
    logic                w_add;
    logic                w_cnt_clr;
    logic                w_valid_nxt;
    logic [CNT_W-1:0]    w_count_nxt;

    assign w_slot_free = !r_m_valid || m_ready_i;
    assign s_ready_o   = ((r_state == ST_IDLE) || (r_state == ST_ACCUM)) && w_slot_free;
    assign w_s_fire    = s_valid_i && s_ready_o;
    assign w_m_fire    = r_m_valid && m_ready_i;
    assign w_full      = (r_count == CNT_FULL);
    assign w_hit_code  = LIT_BASE + CODE_W'(w_hit_idx);
    assign w_wr_idx    = IDX_W'(r_count);

    assign m_valid_o   = r_m_valid;
    assign m_code_o    = r_m_code;
    assign m_last_o    = r_m_last;
    assign dict_full_o = r_dict_full;
    assign busy_o      = r_busy;

    // Parallel match of (current string, incoming symbol) against the live entries.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < int'(DICT_DEPTH); i++) begin
            if ((CNT_W'(i) < r_count) && (r_ent_prefix[i] == r_str) &&
                (r_ent_sym[i] == s_data_i)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_s_fire) begin
                    w_state_nxt = s_last_i ? ST_FLUSH : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_s_fire) begin
                    w_state_nxt = s_last_i ? ST_FLUSH : ST_ACCUM;
`ifdef LZW_DICT_CLEAR_EN
                    if (!w_hit && w_full) begin
                        w_state_nxt = ST_CLR;
                    end
`endif
                end
            end
            ST_CLR: begin
`ifdef LZW_DICT_CLEAR_EN
                if (w_slot_free) begin
                    w_state_nxt = r_pend_last ? ST_FLUSH : ST_ACCUM;
                end
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            ST_FLUSH: begin
                if (w_slot_free) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_m_fire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath controls: code loads, string update, dictionary growth/clear.
    always_comb begin
        w_load      = 1'b0;
        w_load_code = r_m_code;
        w_load_last = 1'b0;
        w_str_nxt   = r_str;
        w_add       = 1'b0;
        w_cnt_clr   = 1'b0;
`ifdef LZW_DICT_CLEAR_EN
        w_pend_last_nxt = r_pend_last;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_s_fire) begin
                    w_str_nxt = CODE_W'(s_data_i);
                end
            end
            ST_ACCUM: begin
                if (w_s_fire) begin
                    if (w_hit) begin
                        w_str_nxt = w_hit_code;
                    end else begin
                        w_load      = 1'b1;
                        w_load_code = r_str;
                        w_str_nxt   = CODE_W'(s_data_i);
                        w_add       = !w_full;
`ifdef LZW_DICT_CLEAR_EN
                        w_pend_last_nxt = s_last_i;
`endif
                    end
                end
            end
            ST_CLR: begin
`ifdef LZW_DICT_CLEAR_EN
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_code = CLR_CODE;
                    w_cnt_clr   = 1'b1;
                end
`endif
            end
            ST_FLUSH: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_code = r_str;
                    w_load_last = 1'b1;
                end
            end
            ST_DONE: begin
                if (w_m_fire) begin
                    w_cnt_clr = 1'b1;
                    w_str_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_valid_nxt = r_m_valid;
        if (w_load) begin
            w_valid_nxt = 1'b1;
        end else if (w_m_fire) begin
            w_valid_nxt = 1'b0;
        end
        w_count_nxt = r_count;
        if (w_cnt_clr) begin
            w_count_nxt = '0;
        end else if (w_add) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            r_str       <= '0;
            r_count     <= '0;
            r_m_valid   <= 1'b0;
            r_m_code    <= '0;
            r_m_last    <= 1'b0;
            r_dict_full <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_str       <= w_str_nxt;
            r_count     <= w_count_nxt;
            r_m_valid   <= w_valid_nxt;
            r_dict_full <= (w_count_nxt == CNT_FULL);
            r_busy      <= (w_state_nxt != ST_IDLE) || w_valid_nxt;
            if (w_load) begin
                r_m_code <= w_load_code;
                r_m_last <= w_load_last;
            end else if (w_m_fire) begin
                r_m_last <= 1'b0;
            end
        end
    end

`ifdef LZW_DICT_CLEAR_EN
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            r_pend_last <= 1'b0;
        end else begin
            r_pend_last <= w_pend_last_nxt;
        end
    end
`endif

    // Entry storage needs no reset: the entry count gates every match.
    always_ff @(posedge clk) begin
        if (w_add) begin
            r_ent_prefix[w_wr_idx] <= r_str;
            r_ent_sym[w_wr_idx]    <= s_data_i;
        end
    end

endmodule
